// File: rtl/qpu_exu_meas_hist.sv
// Per-qubit measurement result history with pending tracking, fast-feedback flags
// and a one-cycle-latency indexed read port.
module qpu_exu_meas_hist #(
    parameter int  QUBIT_NUM  = 12,
    parameter int  HIST_DEPTH = 4,
    localparam int QW         = $clog2(QUBIT_NUM),
    localparam int HW         = $clog2(HIST_DEPTH),
    localparam int CW         = $clog2(HIST_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_issue_en,
    input  logic [QUBIT_NUM-1:0] meas_issue_list,
    input  logic                 meas_ret_en,
    input  logic [QUBIT_NUM-1:0] meas_ret_list,
    input  logic [QUBIT_NUM-1:0] meas_ret_data,
    input  logic                 clr_en,
    input  logic [QUBIT_NUM-1:0] clr_list,
    input  logic                 rd_req,
    input  logic [QW-1:0]        rd_qidx,
    input  logic [HW-1:0]        rd_ofs,
    output logic                 rd_ack,
    output logic                 rd_data,
    output logic                 rd_vld,
    output logic [QUBIT_NUM-1:0] meas_pend,
    output logic [QUBIT_NUM-1:0] meas_vld,
    output logic [QUBIT_NUM-1:0] meas_one,
    output logic [QUBIT_NUM-1:0] meas_zero,
    output logic [QUBIT_NUM-1:0] meas_equ,
    output logic                 err_spur
);

    // Read-select vectors are padded to the full rd_qidx range so out-of-range
    // indices land on constant-zero entries instead of needing a separate guard.
    localparam int NP = 1 << QW;

    localparam logic [HW-1:0] HW_ONE  = HW'(1);
    localparam logic [HW-1:0] HW_TWO  = HW'(2);
    localparam logic [CW-1:0] CW_ONE  = CW'(1);
    localparam logic [CW-1:0] CW_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_MAX = CW'(HIST_DEPTH);

    logic [NP-1:0]        rd_bit_w;
    logic [NP-1:0]        rd_hit_w;
    logic [QUBIT_NUM-1:0] spur_w;

    logic rd_ack_q, rd_ack_d;
    logic rd_data_q, rd_data_d;
    logic rd_vld_q, rd_vld_d;
    logic err_spur_q, err_spur_d;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_q
            if (gi < QUBIT_NUM) begin : g_live
                logic [HIST_DEPTH-1:0] hist_q, hist_d;
                logic [HW-1:0]         wp_q, wp_d, wp_base;
                logic [CW-1:0]         cnt_q, cnt_d, cnt_base;
                logic                  pend_q, pend_d;
                logic                  iss, ret, clr;
                logic [HW-1:0]         rd_idx, newest_idx, prev_idx;
                logic                  newest, previous;

                always_comb begin
                    iss      = meas_issue_en & meas_issue_list[gi];
                    ret      = meas_ret_en & meas_ret_list[gi] & pend_q;
                    clr      = clr_en & clr_list[gi];
                    // A clear takes effect before a same-cycle return lands.
                    wp_base  = clr ? '0 : wp_q;
                    cnt_base = clr ? '0 : cnt_q;
                    hist_d   = hist_q;
                    wp_d     = wp_base;
                    cnt_d    = cnt_base;
                    if (ret) begin
                        hist_d[wp_base] = meas_ret_data[gi];
                        wp_d            = wp_base + HW_ONE;
                        cnt_d           = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CW_ONE;
                    end
                    pend_d = iss | (pend_q & ~ret);
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        hist_q <= '0;
                        wp_q   <= '0;
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                    end else begin
                        hist_q <= hist_d;
                        wp_q   <= wp_d;
                        cnt_q  <= cnt_d;
                        pend_q <= pend_d;
                    end
                end

                assign newest_idx = wp_q - HW_ONE;
                assign prev_idx   = wp_q - HW_TWO;
                assign newest     = hist_q[newest_idx];
                assign previous   = hist_q[prev_idx];
                assign rd_idx     = wp_q - HW_ONE - rd_ofs;

                assign rd_bit_w[gi]  = hist_q[rd_idx];
                assign rd_hit_w[gi]  = ({{(CW-HW){1'b0}}, rd_ofs} < cnt_q);
                assign spur_w[gi]    = meas_ret_en & meas_ret_list[gi] & ~pend_q;

                assign meas_pend[gi] = pend_q;
                assign meas_vld[gi]  = (cnt_q != '0);
                assign meas_one[gi]  = (cnt_q != '0) & newest;
                assign meas_zero[gi] = (cnt_q != '0) & ~newest;
                assign meas_equ[gi]  = (cnt_q >= CW_TWO) & (newest == previous);
            end else begin : g_pad
                assign rd_bit_w[gi] = 1'b0;
                assign rd_hit_w[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        rd_ack_d   = rd_req;
        rd_vld_d   = rd_req & rd_hit_w[rd_qidx];
        rd_data_d  = rd_vld_d & rd_bit_w[rd_qidx];
        err_spur_d = err_spur_q | (|spur_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_q   <= 1'b0;
            rd_data_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            err_spur_q <= err_spur_d;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign rd_vld   = rd_vld_q;
    assign err_spur = err_spur_q;

endmodule

// File: tb/tb_qpu_exu_meas_hist.sv
// Directed bench for qpu_exu_meas_hist at QUBIT_NUM=12, HIST_DEPTH=4.
module tb_qpu_exu_meas_hist;

    localparam int QN = 12;

    logic          clk;
    logic          rst;
    logic          meas_issue_en;
    logic [QN-1:0] meas_issue_list;
    logic          meas_ret_en;
    logic [QN-1:0] meas_ret_list;
    logic [QN-1:0] meas_ret_data;
    logic          clr_en;
    logic [QN-1:0] clr_list;
    logic          rd_req;
    logic [3:0]    rd_qidx;
    logic [1:0]    rd_ofs;
    logic          rd_ack;
    logic          rd_data;
    logic          rd_vld;
    logic [QN-1:0] meas_pend;
    logic [QN-1:0] meas_vld;
    logic [QN-1:0] meas_one;
    logic [QN-1:0] meas_zero;
    logic [QN-1:0] meas_equ;
    logic          err_spur;

    int passed = 0;
    int total  = 0;

    qpu_exu_meas_hist #(.QUBIT_NUM(QN), .HIST_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .meas_issue_en(meas_issue_en), .meas_issue_list(meas_issue_list),
        .meas_ret_en(meas_ret_en), .meas_ret_list(meas_ret_list), .meas_ret_data(meas_ret_data),
        .clr_en(clr_en), .clr_list(clr_list),
        .rd_req(rd_req), .rd_qidx(rd_qidx), .rd_ofs(rd_ofs),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_vld(rd_vld),
        .meas_pend(meas_pend), .meas_vld(meas_vld), .meas_one(meas_one),
        .meas_zero(meas_zero), .meas_equ(meas_equ), .err_spur(err_spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        meas_issue_en = 0; meas_issue_list = '0;
        meas_ret_en = 0; meas_ret_list = '0; meas_ret_data = '0;
        clr_en = 0; clr_list = '0;
        rd_req = 0; rd_qidx = '0; rd_ofs = '0;
    endtask

    task automatic issue(input int q);
        meas_issue_en = 1; meas_issue_list = QN'(1) << q;
        tick(); idle();
    endtask

    task automatic ret(input int q, input logic d);
        meas_ret_en = 1; meas_ret_list = QN'(1) << q; meas_ret_data = QN'(d) << q;
        tick(); idle();
    endtask

    task automatic test_reset();
        rst = 1; idle(); tick(); tick(); rst = 0;
        total++; if (meas_pend !== '0) $display("FAIL reset_pend got=%h exp=0", meas_pend); else passed++;
        total++; if (meas_vld !== '0) $display("FAIL reset_vld got=%h exp=0", meas_vld); else passed++;
        total++; if ({rd_ack, rd_vld, rd_data, err_spur} !== 4'b0) $display("FAIL reset_misc got=%b exp=0000", {rd_ack, rd_vld, rd_data, err_spur}); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_issue_return();
        issue(3);
        total++; if (meas_pend[3] !== 1'b1) $display("FAIL iss_pend3 got=%b exp=1", meas_pend[3]); else passed++;
        total++; if (meas_vld[3] !== 1'b0) $display("FAIL iss_vld3 got=%b exp=0", meas_vld[3]); else passed++;
        ret(3, 1'b1);
        total++; if (meas_pend[3] !== 1'b0) $display("FAIL ret_pend3 got=%b exp=0", meas_pend[3]); else passed++;
        total++; if ({meas_one[3], meas_zero[3]} !== 2'b10) $display("FAIL ret_one3 got=%b exp=10", {meas_one[3], meas_zero[3]}); else passed++;
        rd_req = 1; rd_qidx = 3; rd_ofs = 0; tick(); idle();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b111) $display("FAIL rd_q3 got=%b exp=111", {rd_ack, rd_vld, rd_data}); else passed++;
        $display("test_issue_return done");
    endtask

    task automatic test_history_wrap();
        logic seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic expv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            issue(0); ret(0, seq[i]);
        end
        total++; if ({meas_vld[0], meas_zero[0], meas_equ[0]} !== 3'b110) $display("FAIL wrap_flags got=%b exp=110", {meas_vld[0], meas_zero[0], meas_equ[0]}); else passed++;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1; rd_qidx = 0; rd_ofs = 2'(i); tick();
            total++; if ({rd_ack, rd_vld, rd_data} !== {2'b11, expv[i]}) $display("FAIL wrap_rd%0d got=%b exp=%b", i, {rd_ack, rd_vld, rd_data}, {2'b11, expv[i]}); else passed++;
        end
        idle(); tick();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b000) $display("FAIL rd_idle got=%b exp=000", {rd_ack, rd_vld, rd_data}); else passed++;
        $display("test_history_wrap done");
    endtask

    task automatic test_spurious();
        ret(5, 1'b1);
        total++; if (meas_vld[5] !== 1'b0) $display("FAIL spur_vld5 got=%b exp=0", meas_vld[5]); else passed++;
        total++; if (err_spur !== 1'b1) $display("FAIL spur_set got=%b exp=1", err_spur); else passed++;
        tick(); tick(); tick();
        total++; if (err_spur !== 1'b1) $display("FAIL spur_hold got=%b exp=1", err_spur); else passed++;
        $display("test_spurious done");
    endtask

    task automatic test_clear_return();
        for (int i = 0; i < 3; i++) begin
            issue(2); ret(2, 1'b1);
        end
        issue(2);
        clr_en = 1; clr_list = QN'(1) << 2;
        meas_ret_en = 1; meas_ret_list = QN'(1) << 2; meas_ret_data = '0;
        tick(); idle();
        total++; if ({meas_vld[2], meas_zero[2], meas_one[2], meas_equ[2]} !== 4'b1100) $display("FAIL clr_flags got=%b exp=1100", {meas_vld[2], meas_zero[2], meas_one[2], meas_equ[2]}); else passed++;
        total++; if (meas_pend[2] !== 1'b0) $display("FAIL clr_pend got=%b exp=0", meas_pend[2]); else passed++;
        rd_req = 1; rd_qidx = 2; rd_ofs = 1; tick();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b100) $display("FAIL clr_rd1 got=%b exp=100", {rd_ack, rd_vld, rd_data}); else passed++;
        rd_ofs = 0; tick(); idle();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b110) $display("FAIL clr_rd0 got=%b exp=110", {rd_ack, rd_vld, rd_data}); else passed++;
        $display("test_clear_return done");
    endtask

    task automatic test_read_bounds();
        rd_req = 1; rd_qidx = 12; rd_ofs = 0; tick();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b100) $display("FAIL rd_q12 got=%b exp=100", {rd_ack, rd_vld, rd_data}); else passed++;
        rd_qidx = 15; rd_ofs = 3; tick();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b100) $display("FAIL rd_q15 got=%b exp=100", {rd_ack, rd_vld, rd_data}); else passed++;
        rd_qidx = 3; rd_ofs = 1; tick(); idle();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b100) $display("FAIL rd_ofs_cnt got=%b exp=100", {rd_ack, rd_vld, rd_data}); else passed++;
        $display("test_read_bounds done");
    endtask

    task automatic test_back_to_back();
        meas_issue_en = 1; meas_issue_list = (QN'(1) << 7) | (QN'(1) << 8); tick(); idle();
        total++; if (meas_pend[8:7] !== 2'b11) $display("FAIL b2b_iss got=%b exp=11", meas_pend[8:7]); else passed++;
        meas_issue_en = 1; meas_issue_list = QN'(1) << 7;
        meas_ret_en = 1; meas_ret_list = (QN'(1) << 7) | (QN'(1) << 8); meas_ret_data = meas_ret_list;
        tick(); idle();
        total++; if (meas_pend[8:7] !== 2'b01) $display("FAIL b2b_pend got=%b exp=01", meas_pend[8:7]); else passed++;
        total++; if (meas_one[8:7] !== 2'b11) $display("FAIL b2b_one got=%b exp=11", meas_one[8:7]); else passed++;
        meas_issue_en = 1; meas_issue_list = QN'(1) << 7;
        meas_ret_en = 1; meas_ret_list = QN'(1) << 7; meas_ret_data = '0;
        rd_req = 1; rd_qidx = 7; rd_ofs = 1; tick(); idle();
        total++; if ({rd_ack, rd_vld} !== 2'b10) $display("FAIL b2b_rd_pre got=%b exp=10", {rd_ack, rd_vld}); else passed++;
        total++; if ({meas_pend[7], meas_zero[7], meas_equ[7]} !== 3'b110) $display("FAIL b2b_q7a got=%b exp=110", {meas_pend[7], meas_zero[7], meas_equ[7]}); else passed++;
        meas_ret_en = 1; meas_ret_list = QN'(1) << 7; meas_ret_data = '0;
        clr_en = 1; clr_list = QN'(1) << 8;
        rd_req = 1; rd_qidx = 8; rd_ofs = 0; tick(); idle();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b111) $display("FAIL b2b_rd_clr got=%b exp=111", {rd_ack, rd_vld, rd_data}); else passed++;
        total++; if ({meas_pend[7], meas_equ[7], meas_vld[8]} !== 3'b010) $display("FAIL b2b_q7b got=%b exp=010", {meas_pend[7], meas_equ[7], meas_vld[8]}); else passed++;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_read();
        issue(4);
        rst = 1; rd_req = 1; rd_qidx = 0; rd_ofs = 1; tick(); rst = 0; idle();
        total++; if ({rd_ack, rd_vld, rd_data, err_spur} !== 4'b0) $display("FAIL rstrd_misc got=%b exp=0000", {rd_ack, rd_vld, rd_data, err_spur}); else passed++;
        total++; if ((meas_vld | meas_one | meas_zero | meas_equ | meas_pend) !== '0) $display("FAIL rstrd_flags got=%h exp=0", meas_vld | meas_one | meas_zero | meas_equ | meas_pend); else passed++;
        rd_req = 1; rd_qidx = 0; rd_ofs = 0; tick(); idle();
        total++; if ({rd_ack, rd_vld, rd_data} !== 3'b100) $display("FAIL rstrd_after got=%b exp=100", {rd_ack, rd_vld, rd_data}); else passed++;
        $display("test_reset_mid_read done");
    endtask

    initial begin
        rst = 1; idle();
        test_reset();
        test_issue_return();
        test_history_wrap();
        test_spurious();
        test_clear_return();
        test_read_bounds();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qpu_exu_meas_hist.md
QPU_EXU_MEAS_HIST -- requirements
Module: qpu_exu_meas_hist

Interface
REQ-001 Parameter QUBIT_NUM, default 12, number of qubit channels (2..32).
REQ-002 Parameter HIST_DEPTH, default 4, per-qubit result history depth (power of 2, 2..16).
REQ-003 Derived widths: QW = clog2(QUBIT_NUM), HW = clog2(HIST_DEPTH), CW = clog2(HIST_DEPTH+1).
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 meas_issue_en  in  1  measurement dispatched for the qubits in meas_issue_list.
REQ-008 meas_issue_list  in  QUBIT_NUM  qubits whose measurement was dispatched.
REQ-009 meas_ret_en  in  1  measurement results returning from the MCU.
REQ-010 meas_ret_list  in  QUBIT_NUM  qubits whose result returns this cycle.
REQ-011 meas_ret_data  in  QUBIT_NUM  result bit per qubit.
REQ-012 clr_en  in  1  history clear request for the qubits in clr_list.
REQ-013 clr_list  in  QUBIT_NUM  qubits whose history is cleared.
REQ-014 rd_req  in  1  FMR read request.
REQ-015 rd_qidx  in  QW  qubit index to read.
REQ-016 rd_ofs  in  HW  history offset; 0 = newest, 1 = previous, and so on.
REQ-017 rd_ack  out  1  read response strobe.
REQ-018 rd_data  out  1  result bit read.
REQ-019 rd_vld  out  1  the addressed entry exists.
REQ-020 meas_pend  out  QUBIT_NUM  per-qubit measurement in flight.
REQ-021 meas_vld  out  QUBIT_NUM  per-qubit history holds at least one entry.
REQ-022 meas_one / meas_zero / meas_equ  out  QUBIT_NUM each  fast-feedback flags.
REQ-023 err_spur  out  1  sticky flag for a result returned for a non-pending qubit.

Function
REQ-024 Each qubit SHALL have a HIST_DEPTH-entry circular buffer, a write pointer wp (HW bits, wraps from HIST_DEPTH-1 to 0) and a fill count cnt (CW bits, saturating at HIST_DEPTH).
REQ-025 Effective issue mask: ISS = meas_issue_list & meas_issue_en; effective return mask: RET = meas_ret_list & meas_ret_en & meas_pend.
REQ-026 For each qubit in RET, the cycle SHALL write meas_ret_data[k] at wp, increment wp modulo HIST_DEPTH, increment cnt saturating, and clear meas_pend[k]; the oldest entry is overwritten once cnt = HIST_DEPTH.
REQ-027 meas_pend[k] SHALL be set by ISS[k]; if ISS[k] and RET[k] occur in the same cycle, the result is written and pend stays 1 because a new measurement is in flight.
REQ-028 A return with meas_ret_en=1 on a qubit whose pend=0 SHALL be ignored (no write) and SHALL set err_spur, which holds until rst.
REQ-029 clr_en SHALL zero wp and cnt for the qubits in clr_list; pend is unaffected.
REQ-030 When clear and a return hit the same qubit in the same cycle, the clear applies first: wp=1, cnt=1, entry 0 = new data.
REQ-031 Read latency is 1 cycle: rd_ack = registered rd_req; rd_data and rd_vld are registered.
REQ-032 Read entry: index (wp-1-rd_ofs) mod HIST_DEPTH; rd_vld=1 only if rd_qidx < QUBIT_NUM and rd_ofs < cnt; otherwise rd_vld=0 and rd_data=0.
REQ-033 A read in the same cycle as a write or clear to the same qubit SHALL return the pre-update state.
REQ-034 When rd_req=0, rd_data and rd_vld SHALL be 0.
REQ-035 Fast-feedback flags, all combinational from registered state:
- meas_vld[k] = (cnt!=0)
- meas_one[k] = vld & newest
- meas_zero[k] = vld & ~newest
- meas_equ[k] = (cnt>=2) & (newest == previous)
REQ-036 Per-qubit logic SHALL be fully independent; any number of qubits SHALL update in the same cycle.

Reset
REQ-037 On rst=1 at a clock edge: all wp, cnt, pend and history bits = 0; err_spur, rd_ack, rd_data and rd_vld = 0; therefore meas_vld, meas_one, meas_zero and meas_equ = 0.
REQ-038 rst SHALL take priority over all other inputs in that cycle, including mid-read, where rd_ack is 0 on the next cycle.

Verification
REQ-039 Issue q3, return data=1 -> pend[3] 1 then 0; meas_one[3]=1; read (3,0) -> rd_ack=1, rd_vld=1, rd_data=1 one cycle later.
REQ-040 Five returns on q0 with data 1,0,1,1,0 at HIST_DEPTH=4 -> cnt=4; offsets 0..3 read 0,1,1,0; meas_equ[0]=0.
REQ-041 Return on q5 with pend[5]=0 -> no write, meas_vld[5]=0, err_spur=1 held until rst.
REQ-042 Same cycle: clear q2 (cnt=3) and return q2 data=0 -> cnt=1, read (2,1) gives rd_vld=0, meas_zero[2]=1.
REQ-043 Read (rd_qidx=12, QUBIT_NUM=12) or rd_ofs >= cnt -> rd_vld=0, rd_data=0, rd_ack=1.
REQ-044 Assert rst during a read request with full histories -> all outputs 0 next cycle; a subsequent read (0,0) returns rd_vld=0.
